// File: rtl/seg7_pkg.sv
// Shared definitions for the scanned 7-segment display: glyph table,
// blank glyph and a constant-function clog2 used for counter widths.
package seg7_pkg;

    // Active-high glyph codes {g,f,e,d,c,b,a} for hex digits 0-F (lowercase b, d)
    localparam logic [6:0] SEG7_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Active-high code for a digit with every segment dark
    localparam logic [6:0] SEG7_BLANK = 7'h00;

    // Ceiling log2 for sizing counters; returns 0 for an argument of 1
    function automatic int seg7_clog2(input int value);
        int result;
        int rem;
        result = 32'sd0;
        rem    = value - 32'sd1;
        while (rem > 32'sd0) begin
            result = result + 32'sd1;
            rem    = rem >>> 32'sd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high 7-segment glyph decoder.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    // Table lookup of the glyph for the selected nibble
    always_comb begin
        glyph = SEG7_HEX[nibble];
    end

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed common-anode hex display driver. The displayed value
// lives in a shadow register refreshed only at frame boundaries (or on
// load_now), so a value changing mid-scan never shows as a torn frame.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int DIGITS       = 2,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int LZ_BLANK     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  en,
    input  logic                  load_now,
    output logic [DIGITS-1:0]     an_n,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic                  frame
);

    localparam int PW = seg7_clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? seg7_clog2(DIGITS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    logic [PW-1:0]        presc_q, presc_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [4*DIGITS-1:0]  shadow_q, shadow_d;
    logic [DIGITS-1:0]    shadow_dp_q, shadow_dp_d;
    logic [DIGITS-1:0]    an_n_q, an_n_d;
    logic [6:0]           seg_n_q, seg_n_d;
    logic                 dp_n_q, dp_n_d;
    logic                 frame_q, frame_d;

    logic                 tick_s;
    logic                 boundary_s;
    logic                 slot_on_s;
    logic                 upper_zero_s;
    logic                 lz_blank_s;
    logic [3:0]           nibble_s;
    logic [6:0]           glyph_s;

    // Prescaler, digit index and shadow capture next-state
    always_comb begin
        tick_s     = (presc_q == PRESC_LAST);
        boundary_s = tick_s && (idx_q == IDX_LAST);

        if (tick_s) begin
            presc_d = {PW{1'b0}};
        end else begin
            presc_d = presc_q + PW'(1);
        end

        if (tick_s && (idx_q == IDX_LAST)) begin
            idx_d = {IW{1'b0}};
        end else if (tick_s) begin
            idx_d = idx_q + IW'(1);
        end else begin
            idx_d = idx_q;
        end

        // A boundary and load_now in the same cycle still make one capture
        if (boundary_s || load_now) begin
            shadow_d    = value;
            shadow_dp_d = dp_in;
        end else begin
            shadow_d    = shadow_q;
            shadow_dp_d = shadow_dp_q;
        end
    end

    // Current digit nibble and leading-zero detection over this and higher digits
    always_comb begin
        nibble_s     = shadow_q[{idx_q, 2'b00} +: 4];
        upper_zero_s = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            upper_zero_s = upper_zero_s &
                           ((IW'(i) < idx_q) | (shadow_q[4*i +: 4] == 4'h0));
        end
        lz_blank_s = (LZ_BLANK != 0) && (idx_q != {IW{1'b0}}) && upper_zero_s;
    end

    seg7_hex_decode u_hex_decode (
        .nibble (nibble_s),
        .glyph  (glyph_s)
    );

    // Output next-state from this cycle's scan position, registered below
    always_comb begin
        slot_on_s = en && (presc_q >= BLANK_END);
        an_n_d    = {DIGITS{1'b1}};
        for (int i = 0; i < DIGITS; i++) begin
            an_n_d[i] = ~(slot_on_s && (IW'(i) == idx_q));
        end

        if (lz_blank_s) begin
            seg_n_d = ~SEG7_BLANK;
        end else begin
            seg_n_d = ~glyph_s;
        end

        dp_n_d  = ~shadow_dp_q[idx_q];
        frame_d = boundary_s;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q     <= {PW{1'b0}};
            idx_q       <= {IW{1'b0}};
            shadow_q    <= {(4*DIGITS){1'b0}};
            shadow_dp_q <= {DIGITS{1'b0}};
            an_n_q      <= {DIGITS{1'b1}};
            seg_n_q     <= 7'h7F;
            dp_n_q      <= 1'b1;
            frame_q     <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            an_n_q      <= an_n_d;
            seg_n_q     <= seg_n_d;
            dp_n_q      <= dp_n_d;
            frame_q     <= frame_d;
        end
    end

    assign an_n  = an_n_q;
    assign seg_n = seg_n_q;
    assign dp_n  = dp_n_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Self-checking bench for seg7_scan_display (DIGITS=2, SCAN_DIV=8,
// BLANK_CYCLES=2). A second instance with leading-zero blanking shares
// the stimulus. Expected outputs come from a model that derives the scan
// position from the cycle count since reset.
module tb_seg7_scan_display;

    localparam int DIGITS   = 2;
    localparam int SCAN_DIV = 8;
    localparam int BLANK    = 2;
    localparam int FRAME    = DIGITS * SCAN_DIV;

    localparam logic [10:0] RESET_OUT = {2'b11, 7'h7F, 1'b1, 1'b0};

    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] value;
    logic [1:0] dp_in;
    logic       en;
    logic       load_now;

    logic [1:0] an_n, an_n_lz;
    logic [6:0] seg_n, seg_n_lz;
    logic       dp_n, dp_n_lz;
    logic       frame, frame_lz;

    int n_pass  = 0;
    int n_total = 0;

    // Model state: cycles since reset and the latched shadow value
    int          m_cyc;
    logic [7:0]  m_sh;
    logic [1:0]  m_dp;
    logic [10:0] exp_main;
    logic [10:0] exp_lz;

    always #5 clk = ~clk;

    seg7_scan_display #(
        .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_CYCLES(BLANK), .LZ_BLANK(0)
    ) dut (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .en(en),
        .load_now(load_now), .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n), .frame(frame)
    );

    seg7_scan_display #(
        .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_CYCLES(BLANK), .LZ_BLANK(1)
    ) dut_lz (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .en(en),
        .load_now(load_now), .an_n(an_n_lz), .seg_n(seg_n_lz), .dp_n(dp_n_lz),
        .frame(frame_lz)
    );

    // Predict the outputs after the coming edge, then clock and settle
    task automatic cycle();
        int         p;
        int         ix;
        logic [3:0] nib;
        logic [6:0] seg;
        logic [6:0] seg_lz;
        logic [1:0] an;
        logic       dpn;
        logic       bnd;
        if (rst) begin
            exp_main = RESET_OUT;
            exp_lz   = RESET_OUT;
            m_cyc    = 0;
            m_sh     = 8'h00;
            m_dp     = 2'b00;
        end else begin
            p      = m_cyc % SCAN_DIV;
            ix     = (m_cyc / SCAN_DIV) % DIGITS;
            nib    = 4'((m_sh >> (4 * ix)) & 8'h0F);
            seg    = ~GLYPH[nib];
            seg_lz = (ix > 0 && (m_sh >> (4 * ix)) == 8'h00) ? 7'h7F : seg;
            dpn    = ~m_dp[ix[0]];
            an     = (en && p >= BLANK) ? ~(2'b01 << ix) : 2'b11;
            bnd    = (p == SCAN_DIV - 1) && (ix == DIGITS - 1);
            exp_main = {an, seg, dpn, bnd};
            exp_lz   = {an, seg_lz, dpn, bnd};
            if (bnd || load_now) begin
                m_sh = value;
                m_dp = dp_in;
            end
            m_cyc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        n_total++;
        if ({an_n, seg_n, dp_n, frame} !== RESET_OUT)
            $display("FAIL reset_main got=%h want=%h", {an_n, seg_n, dp_n, frame}, RESET_OUT);
        else n_pass++;
        n_total++;
        if ({an_n_lz, seg_n_lz, dp_n_lz, frame_lz} !== RESET_OUT)
            $display("FAIL reset_lz got=%h want=%h", {an_n_lz, seg_n_lz, dp_n_lz, frame_lz}, RESET_OUT);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_scan_basic();
        rst = 1'b1;
        cycle();
        rst = 1'b0; value = 8'h3A; dp_in = 2'b00; en = 1'b1; load_now = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            cycle();
            n_total++;
            if ({an_n, seg_n, dp_n, frame} !== exp_main)
                $display("FAIL scan_basic k=%0d got=%h want=%h", k, {an_n, seg_n, dp_n, frame}, exp_main);
            else n_pass++;
            if (k == 10) begin
                n_total++;
                if (seg_n !== ~7'h3F)
                    $display("FAIL first_frame_zero got=%h want=%h", seg_n, ~7'h3F);
                else n_pass++;
            end
            if (k == 16) begin
                n_total++;
                if (frame !== 1'b1) $display("FAIL frame_pulse got=%b want=1", frame);
                else n_pass++;
            end
            if (k == 19) begin
                n_total++;
                if ({an_n, seg_n} !== {2'b10, ~7'h77})
                    $display("FAIL digit0_A got=%h want=%h", {an_n, seg_n}, {2'b10, ~7'h77});
                else n_pass++;
            end
            if (k == 27) begin
                n_total++;
                if ({an_n, seg_n} !== {2'b01, ~7'h4F})
                    $display("FAIL digit1_3 got=%h want=%h", {an_n, seg_n}, {2'b01, ~7'h4F});
                else n_pass++;
            end
        end
    endtask

    task automatic test_midframe_change();
        // Land on prescaler 3 of the digit 0 slot before changing the value
        for (int k = 0; k < FRAME && (m_cyc % FRAME) != 3; k++) cycle();
        value = 8'h55;
        for (int k = 0; k < 2 * FRAME; k++) begin
            cycle();
            n_total++;
            if ({an_n, seg_n, dp_n, frame} !== exp_main)
                $display("FAIL midframe k=%0d got=%h want=%h", k, {an_n, seg_n, dp_n, frame}, exp_main);
            else n_pass++;
        end
    endtask

    task automatic test_load_now();
        for (int k = 0; k < FRAME && (m_cyc % FRAME) != 4; k++) cycle();
        value = 8'hF0; dp_in = 2'b01; load_now = 1'b1;
        cycle();
        load_now = 1'b0;
        n_total++;
        if ({seg_n, frame} !== {~7'h6D, 1'b0})
            $display("FAIL load_now_edge got=%h want=%h", {seg_n, frame}, {~7'h6D, 1'b0});
        else n_pass++;
        cycle();
        n_total++;
        if ({seg_n, dp_n, frame} !== {~7'h3F, 1'b0, 1'b0})
            $display("FAIL load_now_next got=%h want=%h", {seg_n, dp_n, frame}, {~7'h3F, 1'b0, 1'b0});
        else n_pass++;
        // load_now on the boundary itself: one capture, frame still pulses
        for (int k = 0; k < FRAME && (m_cyc % FRAME) != FRAME - 1; k++) cycle();
        value = 8'h12; dp_in = 2'b10; load_now = 1'b1;
        cycle();
        load_now = 1'b0;
        n_total++;
        if (frame !== 1'b1) $display("FAIL load_on_boundary_frame got=%b want=1", frame);
        else n_pass++;
        for (int k = 0; k < FRAME; k++) begin
            cycle();
            n_total++;
            if ({an_n, seg_n, dp_n, frame} !== exp_main)
                $display("FAIL load_follow k=%0d got=%h want=%h", k, {an_n, seg_n, dp_n, frame}, exp_main);
            else n_pass++;
        end
    endtask

    task automatic test_enable_off();
        int pulses;
        pulses = 0;
        en = 1'b0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            cycle();
            if (frame === 1'b1) pulses++;
            n_total++;
            if ({an_n, seg_n, dp_n, frame} !== exp_main || an_n !== 2'b11)
                $display("FAIL enable_off k=%0d got=%h want=%h", k, {an_n, seg_n, dp_n, frame}, exp_main);
            else n_pass++;
        end
        n_total++;
        if (pulses != 2) $display("FAIL enable_off_frames got=%0d want=2", pulses);
        else n_pass++;
        en = 1'b1;
    endtask

    task automatic test_lz_blank();
        logic [7:0] vals [2];
        logic [6:0] want0 [2];
        vals[0] = 8'h07; want0[0] = ~7'h07;
        vals[1] = 8'h00; want0[1] = ~7'h3F;
        dp_in = 2'b00;
        for (int v = 0; v < 2; v++) begin
            value = vals[v];
            for (int k = 0; k < 40; k++) begin
                cycle();
                n_total++;
                if ({an_n_lz, seg_n_lz, dp_n_lz, frame_lz} !== exp_lz)
                    $display("FAIL lz_model v=%0d k=%0d got=%h want=%h", v, k, {an_n_lz, seg_n_lz, dp_n_lz, frame_lz}, exp_lz);
                else n_pass++;
                if (k >= 24 && an_n_lz == 2'b01) begin
                    n_total++;
                    if (seg_n_lz !== 7'h7F) $display("FAIL lz_digit1 got=%h want=7f", seg_n_lz);
                    else n_pass++;
                end
                if (k >= 24 && an_n_lz == 2'b10) begin
                    n_total++;
                    if (seg_n_lz !== want0[v]) $display("FAIL lz_digit0 got=%h want=%h", seg_n_lz, want0[v]);
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        value = 8'h99;
        for (int k = 0; k < FRAME && (m_cyc % FRAME) != 13; k++) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        n_total++;
        if ({an_n, seg_n, dp_n, frame} !== RESET_OUT)
            $display("FAIL reset_midframe got=%h want=%h", {an_n, seg_n, dp_n, frame}, RESET_OUT);
        else n_pass++;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            n_total++;
            if ({an_n, seg_n, dp_n, frame} !== exp_main)
                $display("FAIL after_reset k=%0d got=%h want=%h", k, {an_n, seg_n, dp_n, frame}, exp_main);
            else n_pass++;
            if (k == 3) begin
                n_total++;
                if ({an_n, seg_n} !== {2'b10, ~7'h3F})
                    $display("FAIL reset_shows_zero got=%h want=%h", {an_n, seg_n}, {2'b10, ~7'h3F});
                else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 4) == 0) value = 8'($urandom);
            dp_in    = 2'($urandom);
            en       = ($urandom_range(0, 4) != 0);
            load_now = ($urandom_range(0, 9) == 0);
            rst      = ($urandom_range(0, 149) == 0);
            cycle();
            n_total++;
            if ({an_n, seg_n, dp_n, frame} !== exp_main)
                $display("FAIL random_main k=%0d got=%h want=%h", k, {an_n, seg_n, dp_n, frame}, exp_main);
            else n_pass++;
            n_total++;
            if ({an_n_lz, seg_n_lz, dp_n_lz, frame_lz} !== exp_lz)
                $display("FAIL random_lz k=%0d got=%h want=%h", k, {an_n_lz, seg_n_lz, dp_n_lz, frame_lz}, exp_lz);
            else n_pass++;
        end
        rst = 1'b0; load_now = 1'b0; en = 1'b1;
    endtask

    initial begin
        rst = 1'b1; value = 8'h00; dp_in = 2'b00; en = 1'b1; load_now = 1'b0;
        m_cyc = 0; m_sh = 8'h00; m_dp = 2'b00;
        exp_main = RESET_OUT; exp_lz = RESET_OUT;
        test_reset();
        test_scan_basic();
        test_midframe_change();
        test_load_now();
        test_enable_off();
        test_lz_blank();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
